priority_select_pipe: RTL and testbench

PRIORITY_SELECT_PIPE -- requirements
Module: priority_select_pipe

---
 rtl/priority_select_pipe.sv | 108 ++++++++++
 tb/tb_priority_select_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/priority_select_pipe.sv
// Priority channel select with a single registered valid/ready output stage; 1-cycle latency, full throughput.
// Backpressure: o_ready = !o_valid || i_ready. Define PRIOSEL_ROUND_ROBIN_EN for a rotating search start pointer.
module priority_select_pipe #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 1,
  localparam int IDX_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NUM_CH-1:0]        i_ctrl,
  input  logic [NUM_CH*DATA_W-1:0] i_in,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic [IDX_W-1:0]         o_idx,
  output logic                     o_hit
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hit_q, hit_d;

  logic              in_xfer;
  logic              sel_hit;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_data;

`ifdef PRIOSEL_ROUND_ROBIN_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
`endif

  assign o_ready = !valid_q || i_ready;
  assign in_xfer = i_valid && o_ready;

  // Walk the search order from its far end so the earliest candidate is the last one written.
  always_comb begin
    int c;
    c        = 0;
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
`ifdef PRIOSEL_ROUND_ROBIN_EN
      c = int'(ptr_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
`else
      c = k;
`endif
      if (i_ctrl[c]) begin
        sel_hit  = 1'b1;
        sel_idx  = IDX_W'(c);
        sel_data = i_in[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = sel_data;
      idx_d   = sel_idx;
      hit_d   = sel_hit;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef PRIOSEL_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (in_xfer && sel_hit) begin
      ptr_d = (int'(sel_idx) == NUM_CH - 1) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) ptr_q <= '0;
    else           ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_idx   = idx_q;
  assign o_hit   = hit_q;

endmodule

// File: tb/tb_priority_select_pipe.sv
// Directed bench for priority_select_pipe (NUM_CH=4, DATA_W=8) with an abstract reference model checked every cycle.
module tb_priority_select_pipe;

  localparam int NCH = 4;
  localparam int DW  = 8;

`ifdef PRIOSEL_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk;
  logic            arst_n;
  logic            i_valid;
  logic            o_ready;
  logic [NCH-1:0]  i_ctrl;
  logic [NCH*DW-1:0] i_in;
  logic            o_valid;
  logic            i_ready;
  logic [DW-1:0]   o_data;
  logic [1:0]      o_idx;
  logic            o_hit;

  int n_tests = 0;
  int n_fail  = 0;

  priority_select_pipe #(.NUM_CH(NCH), .DATA_W(DW)) dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_ctrl   (i_ctrl),
    .i_in     (i_in),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_idx    (o_idx),
    .o_hit    (o_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: output register contents plus search pointer, as plain integers.
  int m_valid, m_data, m_idx, m_hit, m_ptr;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_valid <= 0; m_data <= 0; m_idx <= 0; m_hit <= 0; m_ptr <= 0;
    end else begin
      if (i_valid && (m_valid == 0 || i_ready)) begin
        int start, found, ch;
        start = RR ? m_ptr : 0;
        found = -1;
        for (int k = 0; k < NCH; k++) begin
          ch = (start + k) % NCH;
          if (found < 0 && i_ctrl[ch]) found = ch;
        end
        m_valid <= 1;
        if (found >= 0) begin
          m_data <= int'(i_in[found*DW +: DW]);
          m_idx  <= found;
          m_hit  <= 1;
          if (RR) m_ptr <= (found + 1) % NCH;
        end else begin
          m_data <= 0; m_idx <= 0; m_hit <= 0;
        end
      end else if (i_ready) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_ready", 32'(o_ready), 32'((m_valid == 0 || i_ready) ? 1 : 0));
    chk("cyc_valid", 32'(o_valid), 32'(m_valid));
    chk("cyc_data",  32'(o_data),  32'(m_data));
    chk("cyc_idx",   32'(o_idx),   32'(m_idx));
    chk("cyc_hit",   32'(o_hit),   32'(m_hit));
  end

  task automatic step(input logic v, input logic [NCH-1:0] ctrl, input logic [NCH*DW-1:0] din,
                      input logic rdy);
    i_valid = v;
    i_ctrl  = ctrl;
    i_in    = din;
    i_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string nm, input int v, input int d, input int ix, input int h);
    chk({nm, "_valid"}, 32'(o_valid), 32'(v));
    chk({nm, "_data"},  32'(o_data),  32'(d));
    chk({nm, "_idx"},   32'(o_idx),   32'(ix));
    chk({nm, "_hit"},   32'(o_hit),   32'(h));
  endtask

  initial begin
    logic [NCH*DW-1:0] lanes;
    arst_n  = 1'b0;
    i_valid = 1'b0;
    i_ctrl  = '0;
    i_in    = '0;
    i_ready = 1'b1;
    #12;
    expect_beat("reset", 0, 0, 0, 0);
    chk("reset_ready", 32'(o_ready), 32'd1);
    #11 arst_n = 1'b1;   // released at t=23, between edges
    @(posedge clk); #1;

    // Lowest set bit of 1010 is channel 1.
    step(1'b1, 4'b1010, 32'h44332211, 1'b1);
    expect_beat("sel_1010", 1, 'h22, 1, 1);

    // No request still yields a (zeroed) beat.
    step(1'b1, 4'b0000, 32'h44332211, 1'b1);
    expect_beat("no_hit", 1, 0, 0, 0);

    // Load lane 2, then stall three cycles while inputs churn.
    step(1'b1, 4'b0100, 32'hDDCCBBAA, 1'b1);
    expect_beat("stall_load", 1, 'hCC, 2, 1);
    for (int i = 0; i < 3; i++) begin
      lanes = 32'h01020304 * (i + 5);
      i_valid = 1'b1; i_ctrl = 4'b0001 << i; i_in = lanes; i_ready = 1'b0;
      #1;
      chk("stall_ready", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
      expect_beat("stall_hold", 1, 'hCC, 2, 1);
    end
    step(1'b0, 4'b1111, 32'hFFFFFFFF, 1'b1);
    expect_beat("drain", 0, 'hCC, 2, 1);

    // Eight back-to-back beats, one-hot so both priority modes agree.
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NCH; c++) lanes[c*DW +: DW] = 8'(i * 16 + c);
      step(1'b1, 4'b0001 << (i % NCH), lanes, 1'b1);
      expect_beat("stream", 1, i * 16 + (i % NCH), i % NCH, 1);
      chk("stream_ready", 32'(o_ready), 32'd1);
    end

    // All channels requesting: rotating vs fixed selection.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1111, 32'h44332211, 1'b1);
      if (RR) expect_beat("rr_seq", 1, 'h11 * ((i % NCH) + 1), i % NCH, 1);
      else    expect_beat("fix_seq", 1, 'h11, 0, 1);
    end
    // Pointer now at 1 (rotating); channel 0 alone must still be found by wrapping.
    step(1'b1, 4'b0001, 32'h44332211, 1'b1);
    expect_beat("wrap", 1, 'h11, 0, 1);

    // Load channel 1 (moves a rotating pointer to 2), stall, then reset asynchronously.
    step(1'b1, 4'b0010, 32'h44332211, 1'b1);
    expect_beat("pre_rst", 1, 'h22, 1, 1);
    step(1'b0, 4'b0000, 32'h0, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    expect_beat("async_rst", 0, 0, 0, 0);
    chk("async_rst_ready", 32'(o_ready), 32'd1);
    #1 arst_n = 1'b1;
    // First edge after release accepts; cleared pointer selects channel 0.
    step(1'b1, 4'b1111, 32'h44332211, 1'b1);
    expect_beat("post_rst", 1, 'h11, 0, 1);
    step(1'b0, 4'b0000, 32'h0, 1'b1);
    expect_beat("post_rst_drain", 0, 'h11, 0, 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
